// File: rtl/imem_loader_if.sv
// Host byte stream, load control and instruction-memory write port of imem_loader.
// The loader connects through the slave modport, the host/memory side through master.
interface imem_loader_if;
  logic        start;
  logic [8:0]  prog_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        cpu_hold;

  modport master (
    output start, prog_len, byte_valid, byte_data,
    input  byte_ready, we, waddr, wdata, busy, done, cpu_hold
  );

  modport slave (
    input  start, prog_len, byte_valid, byte_data,
    output byte_ready, we, waddr, wdata, busy, done, cpu_hold
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian host byte stream into 32-bit words, writes them to instruction
// memory, pads the remaining words with NOP and holds the core until the image is complete.
module imem_loader #(
  parameter int unsigned DEPTH    = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start, core held in reset
  // RECV  | accepting bytes into the current word
  // WRITE | single-cycle write of the assembled word
  // FILL  | writing NOP into every word not loaded
  // DONE  | image complete, core released
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_FILL, S_DONE} state_t;

  localparam logic [8:0] DEPTH_W  = 9'(DEPTH);
  localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

  state_t      state;
  logic [8:0]  len;
  logic [7:0]  idx;
  logic [1:0]  bcnt;
  logic [31:0] wdata_r;
  logic [31:0] waddr_r;
  logic        we_r;
  logic        byte_ready_r;
  logic        busy_r;
  logic        done_r;
  logic        cpu_hold_r;

  logic [8:0]  cap_len;
  logic [7:0]  idx_nxt;

  assign cap_len = (bus.prog_len > DEPTH_W) ? DEPTH_W : bus.prog_len;
  assign idx_nxt = idx + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      len          <= '0;
      idx          <= '0;
      bcnt         <= '0;
      wdata_r      <= '0;
      waddr_r      <= '0;
      we_r         <= 1'b0;
      byte_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      cpu_hold_r   <= 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            len        <= cap_len;
            idx        <= '0;
            bcnt       <= '0;
            done_r     <= 1'b0;
            busy_r     <= 1'b1;
            cpu_hold_r <= 1'b1;
            waddr_r    <= '0;
            if (cap_len == 9'd0) begin
              state   <= S_FILL;
              we_r    <= 1'b1;
              wdata_r <= NOP_WORD;
            end else begin
              state        <= S_RECV;
              byte_ready_r <= 1'b1;
            end
          end
        end

        S_RECV: begin
          if (bus.byte_valid) begin
            wdata_r[{bcnt, 3'b000} +: 8] <= bus.byte_data;
            if (bcnt == 2'd3) begin
              state        <= S_WRITE;
              bcnt         <= '0;
              byte_ready_r <= 1'b0;
              we_r         <= 1'b1;
              waddr_r      <= {22'd0, idx, 2'b00};
            end else begin
              bcnt <= bcnt + 2'd1;
            end
          end
        end

        S_WRITE: begin
          we_r <= 1'b0;
          if ({1'b0, idx} == len - 9'd1) begin
            if (len < DEPTH_W) begin
              state   <= S_FILL;
              idx     <= idx_nxt;
              we_r    <= 1'b1;
              waddr_r <= {22'd0, idx_nxt, 2'b00};
              wdata_r <= NOP_WORD;
            end else begin
              // full image: index stays on the last word instead of wrapping
              state      <= S_DONE;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              cpu_hold_r <= 1'b0;
            end
          end else begin
            state        <= S_RECV;
            idx          <= idx_nxt;
            byte_ready_r <= 1'b1;
          end
        end

        S_FILL: begin
          if (idx == LAST_IDX) begin
            state      <= S_DONE;
            we_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            cpu_hold_r <= 1'b0;
          end else begin
            idx     <= idx_nxt;
            waddr_r <= {22'd0, idx_nxt, 2'b00};
          end
        end

        default: begin
          state        <= S_IDLE;
          we_r         <= 1'b0;
          byte_ready_r <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
          cpu_hold_r   <= 1'b1;
        end
      endcase
    end
  end

  // reset overrides the registered outputs in the very cycle it is asserted
  assign bus.byte_ready = byte_ready_r & ~reset;
  assign bus.we         = we_r & ~reset;
  assign bus.busy       = busy_r & ~reset;
  assign bus.done       = done_r & ~reset;
  assign bus.cpu_hold   = cpu_hold_r | reset;
  assign bus.waddr      = reset ? 32'd0 : waddr_r;
  assign bus.wdata      = reset ? 32'd0 : wdata_r;
endmodule
